// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The FETCH_CNT_EN build option lives in instr_fetch.sv; this package is unaffected by it.
package fetch_pkg;

    // Default widths used by instr_fetch and jump_lut
    localparam int DEF_IW         = 10;
    localparam int DEF_BW         = 6;
    localparam int DEF_LW         = 4;
    localparam int DEF_START_ADDR = 0;
    localparam int CNT_W          = 16;

    // Fetch sequencer state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Absolute jump targets; entry i is i*64, spreading the targets evenly over a 1K ROM
    localparam logic [9:0] JUMP_TARGETS [16] = '{
        10'd0,   10'd64,  10'd128, 10'd192,
        10'd256, 10'd320, 10'd384, 10'd448,
        10'd512, 10'd576, 10'd640, 10'd704,
        10'd768, 10'd832, 10'd896, 10'd960
    };

endpackage

// File: rtl/jump_lut.sv
// Jump target lookup: maps a LUT index to an absolute PC value.
// Purely combinational so a jump lands in the same cycle the index is presented.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int LW = DEF_LW
) (
    input  logic [LW-1:0] idx_i,
    output logic [IW-1:0] target_o
);

    // Table read, resized to the PC width
    always_comb begin
        target_o = IW'(JUMP_TARGETS[idx_i]);
    end

endmodule

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer driving the instruction ROM address.
// Build option: define FETCH_CNT_EN to add the FetchCount port and its saturating counter.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int IW         = DEF_IW,
    parameter int BW         = DEF_BW,
    parameter int LW         = DEF_LW,
    parameter int START_ADDR = DEF_START_ADDR
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic [BW-1:0]     BranchOff,
    input  logic              JumpEn,
    input  logic [LW-1:0]     JumpIdx,
    output logic [IW-1:0]     ProgCtr,
    output logic              Running,
`ifdef FETCH_CNT_EN
    output logic [CNT_W-1:0]  FetchCount,
`endif
    output logic              Done
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [IW-1:0] jumpTarget;
    logic [IW-1:0] branchTarget;

    jump_lut #(
        .IW (IW),
        .LW (LW)
    ) u_jump_lut (
        .idx_i    (JumpIdx),
        .target_o (jumpTarget)
    );

    // PC-relative target: sign-extend the offset, then wrap modulo 2**IW
    always_comb begin
        branchTarget = pc_q + {{(IW-BW){BranchOff[BW-1]}}, BranchOff};
    end

    // Next state and next PC; halt beats stall beats jump beats branch beats sequential
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = IW'(START_ADDR);
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = DONE;
                end else if (!Stall) begin
                    if (JumpEn) begin
                        pc_d = jumpTarget;
                    end else if (BranchEn) begin
                        pc_d = branchTarget;
                    end else begin
                        pc_d = pc_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and PC registers, cleared immediately on reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        ProgCtr = pc_q;
        Running = (state_q == RUN);
        Done    = (state_q == DONE);
    end

`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts PC advances in RUN, restarts on the Start that enters RUN, sticks at all-ones
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (state_q != RUN && Start) begin
            cnt_q <= '0;
        end else if (state_q == RUN && !Halt && !Stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Expose the counter
    always_comb begin
        FetchCount = cnt_q;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// halt/restart and async-reset sequences, then randomized traffic against a
// behavioural model. Checks FetchCount too when FETCH_CNT_EN is defined.
module tb_instr_fetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Halt = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchEn = 1'b0;
    logic [5:0]  BranchOff = '0;
    logic        JumpEn = 1'b0;
    logic [3:0]  JumpIdx = '0;
    logic [9:0]  ProgCtr;
    logic        Running;
    logic        Done;
`ifdef FETCH_CNT_EN
    logic [15:0] FetchCount;
`endif

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural model: 0 idle, 1 run, 2 done
    int mState = 0;
    int mPc    = 0;
    int mCount = 0;

    typedef struct {
        logic       start, halt, stall, br;
        logic [5:0] off;
        logic       jmp;
        logic [3:0] idx;
        int         expPc;
        logic       expRun, expDone;
    } vec_t;

    vec_t vecs[$];

    instr_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Stall      (Stall),
        .BranchEn   (BranchEn),
        .BranchOff  (BranchOff),
        .JumpEn     (JumpEn),
        .JumpIdx    (JumpIdx),
        .ProgCtr    (ProgCtr),
        .Running    (Running),
`ifdef FETCH_CNT_EN
        .FetchCount (FetchCount),
`endif
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic start, input logic halt, input logic stall,
                                input logic br, input int off, input logic jmp, input int idx,
                                input int expPc, input logic expRun, input logic expDone);
        vec_t v;
        v.start = start; v.halt = halt; v.stall = stall; v.br = br;
        v.off = 6'(off); v.jmp = jmp; v.idx = 4'(idx);
        v.expPc = expPc; v.expRun = expRun; v.expDone = expDone;
        return v;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Spec-level model of one clock edge, using plain arithmetic on the PC
    task automatic modelStep();
        int offS;
        offS = BranchOff[5] ? int'(BranchOff) - 64 : int'(BranchOff);
        if (mState != 1) begin
            if (Start) begin
                mState = 1; mPc = 0; mCount = 0;
            end
        end else if (Halt) begin
            mState = 2;
        end else if (!Stall) begin
            if (JumpEn) mPc = int'(JumpIdx) * 64;
            else if (BranchEn) mPc = (mPc + offS + 1024) % 1024;
            else mPc = (mPc + 1) % 1024;
            if (mCount < 65535) mCount++;
        end
    endtask

    task automatic modelReset();
        mState = 0; mPc = 0; mCount = 0;
    endtask

    // Drive one cycle of inputs away from the edge, clock it, update the model
    task automatic applyStimulus(input logic start, input logic halt, input logic stall,
                                 input logic br, input logic [5:0] off,
                                 input logic jmp, input logic [3:0] idx);
        @(negedge Clk);
        Start = start; Halt = halt; Stall = stall;
        BranchEn = br; BranchOff = off; JumpEn = jmp; JumpIdx = idx;
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".pc"}, int'(ProgCtr), mPc);
        checkVal({tag, ".running"}, int'(Running), int'(mState == 1));
        checkVal({tag, ".done"}, int'(Done), int'(mState == 2));
`ifdef FETCH_CNT_EN
        checkVal({tag, ".count"}, int'(FetchCount), mCount);
`endif
    endtask

    initial begin
        // Directed walk: sequential, stall, branch wrap, jump priority, halt/restart
        vecs.push_back(mk(1,0,0,0,  0,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    1,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    2,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    3,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    4,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    5,1,0));
        vecs.push_back(mk(0,0,1,0,  0,0,0,    5,1,0));
        vecs.push_back(mk(0,0,1,1,  3,1,2,    5,1,0));
        vecs.push_back(mk(0,0,1,0,  0,0,0,    5,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    6,1,0));
        vecs.push_back(mk(0,0,0,1,  4,0,0,   10,1,0));
        vecs.push_back(mk(0,0,0,1, -3,0,0,    7,1,0));
        vecs.push_back(mk(0,0,0,1, -8,0,0, 1023,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,1, -2,0,0, 1022,1,0));
        vecs.push_back(mk(0,0,0,1,  4,0,0,    2,1,0));
        vecs.push_back(mk(0,0,0,0,  0,1,3,  192,1,0));
        vecs.push_back(mk(0,0,0,0,  0,1,0,    0,1,0));
        vecs.push_back(mk(0,0,0,1,  8,0,0,    8,1,0));
        vecs.push_back(mk(0,0,0,1,  5,1,1,   64,1,0));
        vecs.push_back(mk(1,0,0,1,-31,0,0,   33,1,0));
        vecs.push_back(mk(0,0,0,1,-13,0,0,   20,1,0));
        vecs.push_back(mk(0,1,1,1,  5,1,2,   20,0,1));
        vecs.push_back(mk(0,0,0,0,  0,0,0,   20,0,1));
        vecs.push_back(mk(1,0,0,0,  0,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,    1,1,0));
        vecs.push_back(mk(1,0,0,0,  0,0,0,    2,1,0));

        // Reset state holds with no clock edge needed
        #12;
        checkOutput("reset");
        @(negedge Clk);
        Reset = 1'b0;
        modelReset();

        // Start is not required to act in IDLE unless asserted
        applyStimulus(0,0,0,0,'0,0,'0);
        checkOutput("idle_hold");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].halt, vecs[i].stall, vecs[i].br,
                          vecs[i].off, vecs[i].jmp, vecs[i].idx);
            checkOutput($sformatf("vec%0d", i));
            checkVal($sformatf("vec%0d.tbl_pc", i), int'(ProgCtr), vecs[i].expPc);
            checkVal($sformatf("vec%0d.tbl_run", i), int'(Running), int'(vecs[i].expRun));
            checkVal($sformatf("vec%0d.tbl_done", i), int'(Done), int'(vecs[i].expDone));
        end

        // Reach PC=50, then reset asynchronously between edges
        applyStimulus(0,0,0,0,'0,1,4'd0);
        applyStimulus(0,0,0,1,6'd25,0,'0);
        applyStimulus(0,0,0,1,6'd25,0,'0);
        checkVal("pre_reset.pc", int'(ProgCtr), 50);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        checkVal("async_reset.pc0", int'(ProgCtr), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic rs, rh, rst, rb, rj;
            rs  = ($urandom_range(0, 3) == 0);
            rh  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 4) == 0);
            rb  = ($urandom_range(0, 2) == 0);
            rj  = ($urandom_range(0, 4) == 0);
            applyStimulus(rs, rh, rst, rb, 6'($urandom), rj, 4'($urandom));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
